// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled UART receiver with majority-vote sampling,
// configurable framing and a receive FIFO carrying per-word error flags,
// accessed over the peripheral valid/ready register bus.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int MAX_WIDTH = 9,
  parameter int OVS       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        irq,
  input  logic        valid,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(OVS);
  localparam int IW = $clog2(MAX_WIDTH);
  localparam int EW = MAX_WIDTH + 2;
  localparam logic [TW-1:0] T_LO  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_MID = TW'(OVS / 2);
  localparam logic [TW-1:0] T_HI  = TW'(OVS / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  // Even parity of the received data bits (unused upper bits are held at zero)
  function automatic logic parity_of(input logic [MAX_WIDTH-1:0] d);
    return ^d;
  endfunction

  // Width field is stored already clamped to the supported range
  function automatic logic [5:0] clamp_width(input logic [5:0] w);
    if (w < 6'd5) return 6'd5;
    else if (w > 6'(MAX_WIDTH)) return 6'(MAX_WIDTH);
    else return w;
  endfunction

  logic rx_meta_r, rx_sync_r, rx_prev_r;
  logic [15:0] tick_cnt_r, div_r;
  logic [5:0] width_r;
  logic [1:0] par_mode_r;
  logic stop2_r, enable_r;
  logic [7:0] thresh_r;
  logic [3:0] ien_r;
  logic frame_flag_r, par_flag_r, ovr_flag_r;
  state_t state_r, state_nxt_s;
  logic [TW-1:0] t_r;
  logic [IW-1:0] bit_cnt_r;
  logic [MAX_WIDTH-1:0] shift_r;
  logic samp_a_r, samp_b_r, par_err_r, frm_err_r;
  logic [EW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wptr_r, rptr_r;
  logic [AW:0] count_r;

  logic tick_s, start_edge_s, decide_s, bit_end_s, maj_s, par_en_s, last_bit_s;
  logic push_s, push_ok_s, pop_s, push_frm_s, empty_s, full_s, thr_hit_s;
  logic access_s, rd_access_s, wr_access_s;
  logic [2:0] sel_s;
  logic [31:0] wdata_sh_s, rd_val_s;
  logic [EW-1:0] push_word_s, head_s;
  logic unused_s;

  assign unused_s     = ^{size, addr[31:5], wdata_sh_s[31:24]};
  assign tick_s       = (tick_cnt_r == 16'd0);
  assign start_edge_s = rx_prev_r & ~rx_sync_r;
  assign decide_s     = tick_s && (t_r == T_HI);
  assign bit_end_s    = tick_s && (t_r == T_END);
  assign maj_s        = (samp_a_r & samp_b_r) | (samp_a_r & rx_sync_r) | (samp_b_r & rx_sync_r);
  assign par_en_s     = (par_mode_r == 2'd1) || (par_mode_r == 2'd2);
  assign last_bit_s   = (6'(bit_cnt_r) == (width_r - 6'd1));
  assign push_frm_s   = frm_err_r | ~maj_s;
  assign push_word_s  = {push_frm_s, par_err_r, shift_r};

  assign access_s     = valid & ~ready;
  assign rd_access_s  = access_s & ~write;
  assign wr_access_s  = access_s & write;
  assign sel_s        = addr[4:2];
  assign wdata_sh_s   = wdata << {addr[1:0], 3'b000};
  assign empty_s      = (count_r == (AW+1)'(0));
  assign full_s       = (count_r == (AW+1)'(DEPTH));
  assign pop_s        = rd_access_s && (sel_s == 3'd0) && !empty_s;
  assign push_ok_s    = push_s && (!full_s || pop_s);
  assign head_s       = mem_r[rptr_r];
  assign thr_hit_s    = (thresh_r != 8'd0) && (9'(count_r) >= {1'b0, thresh_r});

  // Two-flop synchroniser plus delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Free-running oversample tick: one tick every DIV+1 clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt_r <= 16'd0;
    else if (tick_s) tick_cnt_r <= div_r;
    else tick_cnt_r <= tick_cnt_r - 16'd1;
  end

  // Receiver state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else state_r <= state_nxt_s;
  end

  // Next-state and push decision; leaving enable low forces IDLE
  always_comb begin
    state_nxt_s = state_r;
    push_s      = 1'b0;
    if (!enable_r) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:   if (start_edge_s) state_nxt_s = START; else state_nxt_s = IDLE;
        START: begin
          if (decide_s && maj_s) state_nxt_s = IDLE;
          else if (bit_end_s) state_nxt_s = DATA;
          else state_nxt_s = START;
        end
        DATA: begin
          if (bit_end_s && last_bit_s) state_nxt_s = par_en_s ? PARITY : STOP1;
          else state_nxt_s = DATA;
        end
        PARITY: if (bit_end_s) state_nxt_s = STOP1; else state_nxt_s = PARITY;
        STOP1: begin
          if (decide_s && !stop2_r) begin
            push_s      = 1'b1;
            state_nxt_s = IDLE;
          end else if (bit_end_s && stop2_r) begin
            state_nxt_s = STOP2;
          end else begin
            state_nxt_s = STOP1;
          end
        end
        STOP2: begin
          if (decide_s) begin
            push_s      = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = STOP2;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Bit timing, majority samples, data shift and per-frame error capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_r <= '0; bit_cnt_r <= '0; shift_r <= '0;
      samp_a_r <= 1'b1; samp_b_r <= 1'b1; par_err_r <= 1'b0; frm_err_r <= 1'b0;
    end else if (state_r == IDLE) begin
      t_r <= '0; bit_cnt_r <= '0; shift_r <= '0;
      par_err_r <= 1'b0; frm_err_r <= 1'b0;
    end else begin
      if (tick_s) t_r <= (t_r == T_END) ? '0 : t_r + TW'(1);
      if (tick_s && t_r == T_LO) samp_a_r <= rx_sync_r;
      if (tick_s && t_r == T_MID) samp_b_r <= rx_sync_r;
      if (decide_s) begin
        case (state_r)
          DATA:    shift_r[bit_cnt_r] <= maj_s;
          PARITY:  par_err_r <= (par_mode_r == 2'd2) ? ~(parity_of(shift_r) ^ maj_s)
                                                     : (parity_of(shift_r) ^ maj_s);
          STOP1:   frm_err_r <= frm_err_r | ~maj_s;
          default: frm_err_r <= frm_err_r;
        endcase
      end
      if (bit_end_s && state_r == DATA) bit_cnt_r <= bit_cnt_r + IW'(1);
    end
  end

  // FIFO storage (pointers and level carry the reset)
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wptr_r] <= push_word_s;
  end

  // FIFO pointers and level; a full FIFO still accepts a push alongside a pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r <= '0; rptr_r <= '0; count_r <= '0;
    end else begin
      if (push_ok_s) wptr_r <= wptr_r + AW'(1);
      if (pop_s) rptr_r <= rptr_r + AW'(1);
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Configuration registers and sticky status flags (set wins over clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r <= 16'h001F; width_r <= 6'd8; par_mode_r <= 2'd0; stop2_r <= 1'b0;
      enable_r <= 1'b0; thresh_r <= 8'd1; ien_r <= 4'd0;
      frame_flag_r <= 1'b0; par_flag_r <= 1'b0; ovr_flag_r <= 1'b0;
    end else begin
      if (wr_access_s && sel_s == 3'd1) div_r <= wdata_sh_s[15:0];
      if (wr_access_s && sel_s == 3'd2) begin
        width_r    <= clamp_width(wdata_sh_s[5:0]);
        par_mode_r <= wdata_sh_s[7:6];
        stop2_r    <= wdata_sh_s[8];
        enable_r   <= wdata_sh_s[9];
        thresh_r   <= wdata_sh_s[23:16];
      end
      if (wr_access_s && sel_s == 3'd4) ien_r <= wdata_sh_s[3:0];
      frame_flag_r <= (push_s & push_frm_s) |
                      (frame_flag_r & ~(wr_access_s && sel_s == 3'd3 && wdata_sh_s[11]));
      par_flag_r   <= (push_s & par_err_r) |
                      (par_flag_r & ~(wr_access_s && sel_s == 3'd3 && wdata_sh_s[12]));
      ovr_flag_r   <= (push_s & full_s & ~pop_s) |
                      (ovr_flag_r & ~(wr_access_s && sel_s == 3'd3 && wdata_sh_s[13]));
    end
  end

  // Read-data multiplexer; an empty DATA read reports only the empty bit
  always_comb begin
    rd_val_s = 32'd0;
    case (sel_s)
      3'd0: begin
        if (empty_s) begin
          rd_val_s = 32'h8000_0000;
        end else begin
          rd_val_s[MAX_WIDTH-1:0] = head_s[MAX_WIDTH-1:0];
          rd_val_s[29] = head_s[MAX_WIDTH];
          rd_val_s[30] = head_s[MAX_WIDTH+1];
        end
      end
      3'd1:    rd_val_s = {16'd0, div_r};
      3'd2:    rd_val_s = {8'd0, thresh_r, 6'd0, enable_r, stop2_r, par_mode_r, width_r};
      3'd3:    rd_val_s = {17'd0, (state_r != IDLE), ovr_flag_r, par_flag_r, frame_flag_r,
                           full_s, empty_s, 9'(count_r)};
      3'd4:    rd_val_s = {28'd0, ien_r};
      default: rd_val_s = 32'd0;
    endcase
  end

  // Bus response: ready echoes valid, rdata captured on the access cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready <= 1'b0;
      rdata <= 32'd0;
    end else begin
      ready <= valid;
      if (access_s) rdata <= write ? 32'd0 : (rd_val_s >> {addr[1:0], 3'b000});
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else irq <= |(ien_r & {ovr_flag_r, par_flag_r, frame_flag_r, thr_hit_s});
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DIV=0, so one bit = 16 clk).
module tb_uart_rx_fifo;
  logic        clk = 1'b0;
  logic        rst, rx, irq, valid, write, ready;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  size;
  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  uart_rx_fifo #(.DEPTH(16), .MAX_WIDTH(9), .OVS(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .irq(irq), .valid(valid), .write(write),
    .addr(addr), .size(size), .wdata(wdata), .rdata(rdata), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge two clocks later
  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    valid = 1'b1; write = 1'b0; addr = a;
    @(posedge clk); @(negedge clk);
    d = rdata;
    valid = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    valid = 1'b1; write = 1'b1; addr = a; wdata = d;
    @(posedge clk); @(negedge clk);
    valid = 1'b0; write = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (16) @(negedge clk);
  endtask

  // pmode: 0 none, 1 even, 2 odd; pflip inverts the parity bit
  task automatic send_frame(input int w, input logic [15:0] d, input int pmode,
                            input logic pflip, input logic two_stop, input logic stop_val);
    logic p;
    p = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < w; i++) begin
      send_bit(d[i]);
      p = p ^ d[i];
    end
    if (pmode == 1) send_bit(p ^ pflip);
    else if (pmode == 2) send_bit(~p ^ pflip);
    send_bit(stop_val);
    if (two_stop) send_bit(1'b1);
    rx = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; valid = 1'b0; write = 1'b0;
    addr = 32'd0; wdata = 32'd0; size = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus_rd(32'h0C, rd); chk("rst_stat", rd, 32'h0000_0200);
    bus_rd(32'h08, rd); chk("rst_ctrl", rd, 32'h0001_0008);
    bus_rd(32'h0A, rd); chk("ctrl_lane2", rd, 32'h0000_0001);
    bus_rd(32'h04, rd); chk("rst_div", rd, 32'h0000_001F);
    bus_rd(32'h14, rd); chk("unmapped", rd, 32'h0000_0000);
    bus_rd(32'h00, rd); chk("rst_data_empty", rd, 32'h8000_0000);

    bus_wr(32'h08, 32'h0000_0002); bus_rd(32'h08, rd); chk("clamp_lo", rd, 32'h0000_0005);
    bus_wr(32'h08, 32'h0000_0014); bus_rd(32'h08, rd); chk("clamp_hi", rd, 32'h0000_0009);

    // 8N1 back-to-back
    bus_wr(32'h04, 32'h0000_0000);
    bus_wr(32'h08, 32'h0001_0208);
    repeat (40) @(negedge clk);
    send_frame(8, 16'h0055, 0, 1'b0, 1'b0, 1'b1);
    send_frame(8, 16'h00A3, 0, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    bus_rd(32'h00, rd); chk("t1_word0", rd, 32'h0000_0055);
    bus_rd(32'h00, rd); chk("t1_word1", rd, 32'h0000_00A3);
    bus_rd(32'h00, rd); chk("t1_empty", rd, 32'h8000_0000);

    // Short glitch: false start
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    bus_rd(32'h0C, rd); chk("glitch_busy", rd, 32'h0000_4200);
    repeat (40) @(negedge clk);
    bus_rd(32'h0C, rd); chk("glitch_idle", rd, 32'h0000_0200);

    // 9 bits, odd parity, 2 stop bits
    bus_wr(32'h08, 32'h0001_0389);
    repeat (4) @(negedge clk);
    send_frame(9, 16'h01A5, 2, 1'b0, 1'b1, 1'b1);
    send_frame(9, 16'h00F0, 2, 1'b1, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    bus_rd(32'h00, rd); chk("t2_word0", rd, 32'h0000_01A5);
    bus_rd(32'h00, rd); chk("t2_word1", rd, 32'h2000_00F0);
    bus_rd(32'h0C, rd); chk("t2_stat_par", rd, 32'h0000_1200);
    bus_wr(32'h0C, 32'h0000_1000);
    bus_rd(32'h0C, rd); chk("t2_stat_clr", rd, 32'h0000_0200);

    // Stop bit low -> frame error
    bus_wr(32'h08, 32'h0001_0208);
    repeat (4) @(negedge clk);
    send_frame(8, 16'h003C, 0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("t3_irq_masked", {31'd0, irq}, 32'd0);
    bus_wr(32'h10, 32'h0000_0002);
    repeat (3) @(negedge clk);
    chk("t3_irq_frame", {31'd0, irq}, 32'd1);
    bus_rd(32'h00, rd); chk("t3_word", rd, 32'h4000_003C);
    bus_rd(32'h0C, rd); chk("t3_stat", rd, 32'h0000_0A00);
    bus_wr(32'h0C, 32'h0000_0800);
    bus_wr(32'h10, 32'h0000_0000);
    repeat (3) @(negedge clk);
    chk("t3_irq_clr", {31'd0, irq}, 32'd0);

    // DEPTH+1 frames, no reads
    for (int i = 0; i < 17; i++) send_frame(8, 16'((i * 37 + 5) & 8'hFF), 0, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    bus_rd(32'h0C, rd); chk("t5_stat_full", rd, 32'h0000_2410);
    for (int i = 0; i < 16; i++) begin
      bus_rd(32'h00, rd); chk($sformatf("t5_word%0d", i), rd, 32'((i * 37 + 5) & 8'hFF));
    end
    bus_rd(32'h0C, rd); chk("t5_stat_drained", rd, 32'h0000_2200);
    bus_wr(32'h0C, 32'h0000_2000);
    bus_rd(32'h0C, rd); chk("t5_stat_clr", rd, 32'h0000_0200);

    // Threshold interrupt, then reset mid-frame
    bus_wr(32'h08, 32'h0003_0208);
    bus_wr(32'h10, 32'h0000_0001);
    repeat (4) @(negedge clk);
    send_frame(8, 16'h0011, 0, 1'b0, 1'b0, 1'b1);
    send_frame(8, 16'h0022, 0, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("t6_irq_two", {31'd0, irq}, 32'd0);
    send_frame(8, 16'h0033, 0, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("t6_irq_three", {31'd0, irq}, 32'd1);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    bus_rd(32'h0C, rd); chk("t6_stat_busy", rd, 32'h0000_4003);
    rst = 1'b1;
    #1;
    chk("t6_rst_irq", {31'd0, irq}, 32'd0);
    chk("t6_rst_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0; rx = 1'b1;
    @(negedge clk);
    bus_rd(32'h0C, rd); chk("t6_stat_after_rst", rd, 32'h0000_0200);
    bus_rd(32'h00, rd); chk("t6_data_after_rst", rd, 32'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
